// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_if
// Description : Pin-side and conditioned-output bundle for input_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================

interface input_conditioner_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_out;
    logic [WIDTH-1:0] fall_out;
    logic             tick_out;

    modport master (
        output raw_in,
        input  level_out,
        input  rise_out,
        input  fall_out,
        input  tick_out
    );

    modport slave (
        input  raw_in,
        output level_out,
        output rise_out,
        output fall_out,
        output tick_out
    );
endinterface

`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : 2-flop synchroniser, tick-based debouncer and edge pulses for
//               board switches/buttons.
// Revision    : 1.0 - initial release
// ============================================================================

module input_conditioner #(
    parameter int WIDTH        = 12,
    parameter int TICK_DIV     = 125000,
    parameter int STABLE_TICKS = 10
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input_conditioner_if.slave pins
);

    localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    localparam logic [c_PW-1:0] c_PCNT_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [c_PW-1:0]  r_pcnt;
    logic             r_tick;
    logic             w_tick;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= pins.raw_in;
            r_s2 <= r_s1;
        end
    end

    assign w_tick = (r_pcnt == c_PCNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
            r_pcnt <= w_tick ? '0 : r_pcnt + c_PW'(1);
        end
    end

    // Each channel keeps its own run-length of mismatching ticks; any tick that
    // agrees with the current level discards the partial run.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        logic [c_CW-1:0] r_cnt;
        logic            r_level;
        logic            r_rise;
        logic            r_fall;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (w_tick) begin
                    if (r_s2[gi] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_level <= r_s2[gi];
                        r_cnt   <= '0;
                        r_rise  <= r_s2[gi];
                        r_fall  <= ~r_s2[gi];
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
            end
        end

        assign w_level[gi] = r_level;
        assign w_rise[gi]  = r_rise;
        assign w_fall[gi]  = r_fall;
    end

    assign pins.level_out = w_level;
    assign pins.rise_out  = w_rise;
    assign pins.fall_out  = w_fall;
    assign pins.tick_out  = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Randomised and directed self-checking bench for input_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_input_conditioner;

    localparam int W  = 4;
    localparam int TD = 4;
    localparam int ST = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    input_conditioner_if #(.WIDTH(W)) pins ();

    input_conditioner #(
        .WIDTH        (W),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: level flips when the last ST tick samples of the
    // synchronised input (since reset / last change) all disagree with it.
    logic [W-1:0] m_s1    = '0;
    logic [W-1:0] m_s2    = '0;
    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_rise  = '0;
    logic [W-1:0] m_fall  = '0;
    logic         m_tick  = 1'b0;
    int           m_edges = 0;
    logic [W-1:0] m_samp[$];
    int           m_from[W];
    int           m_n;
    bit           m_diff;

    initial begin
        for (int i = 0; i < W; i++) m_from[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
                m_tick = 1'b0; m_edges = 0;
                m_samp.delete();
                for (int i = 0; i < W; i++) m_from[i] = 0;
            end else begin
                m_edges++;
                m_tick = ((m_edges % TD) == 0);
                m_rise = '0;
                m_fall = '0;
                if (m_tick) begin
                    m_samp.push_back(m_s2);
                    m_n = m_samp.size();
                    for (int i = 0; i < W; i++) begin
                        m_diff = ((m_n - m_from[i]) >= ST);
                        for (int k = m_n - ST; k < m_n && m_diff; k++)
                            if (m_samp[k][i] == m_level[i]) m_diff = 1'b0;
                        if (m_diff) begin
                            m_level[i] = ~m_level[i];
                            m_rise[i]  = m_level[i];
                            m_fall[i]  = ~m_level[i];
                            m_from[i]  = m_n;
                        end
                    end
                end
                m_s2 = m_s1;
                m_s1 = pins.raw_in;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("level", 32'(pins.level_out), 32'(m_level));
                check("rise",  32'(pins.rise_out),  32'(m_rise));
                check("fall",  32'(pins.fall_out),  32'(m_fall));
                check("tick",  32'(pins.tick_out),  32'(m_tick));
            end
        end
    end

    int rise_cnt[W];
    int fall_cnt[W];
    initial begin
        for (int i = 0; i < W; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < W; i++) begin
                if (pins.rise_out[i] === 1'b1) rise_cnt[i]++;
                if (pins.fall_out[i] === 1'b1) fall_cnt[i]++;
            end
        end
    end

    task automatic wait_level(int ch, logic val, int maxc, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (pins.level_out[ch] !== val && lat < maxc);
        check($sformatf("wait_level_ch%0d", ch), 32'(pins.level_out[ch]), 32'(val));
    endtask

    task automatic reset_pulse(int cycles);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_level", 32'(pins.level_out), 32'd0);
        check("async_reset_pulses", 32'({pins.rise_out, pins.fall_out, pins.tick_out}), 32'd0);
        repeat (cycles) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int lat;
    int r0;
    int f0;

    initial begin
        pins.raw_in = 4'hF;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_level", 32'(pins.level_out), 32'd0);

        // Input held high through release: accepted on edge 12 (ticks 4, 8, 12).
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("t1_level", 32'(pins.level_out), (k >= 12) ? 32'hF : 32'h0);
            check("t1_rise",  32'(pins.rise_out),  (k == 12) ? 32'hF : 32'h0);
            if (k == 12) check("t1_model_pin", 32'(m_level), 32'hF);
        end

        pins.raw_in = 4'h0;
        repeat (20) @(negedge clk);
        check("t2_all_low", 32'(pins.level_out), 32'h0);

        repeat ($urandom_range(0, 3)) @(negedge clk);
        f0 = fall_cnt[0];
        pins.raw_in[0] = 1'b1;
        wait_level(0, 1'b1, 20, lat);
        check("t2_latency_ok", 32'(lat >= 11 && lat <= 15), 32'd1);
        check("t2_no_fall", 32'(fall_cnt[0] - f0), 32'd0);

        r0 = rise_cnt[1];
        for (int j = 0; j < 8; j++) begin
            pins.raw_in[1] = (j % 2 == 0);
            repeat (5) @(negedge clk);
        end
        check("t3_bounce_level", 32'(pins.level_out[1]), 32'd0);
        check("t3_bounce_rises", 32'(rise_cnt[1] - r0), 32'd0);
        pins.raw_in[1] = 1'b1;
        wait_level(1, 1'b1, 20, lat);
        repeat (10) @(negedge clk);
        check("t3_single_rise", 32'(rise_cnt[1] - r0), 32'd1);

        pins.raw_in[2] = 1'b1;
        wait_level(2, 1'b1, 20, lat);
        f0 = fall_cnt[2];
        pins.raw_in[2] = 1'b0;
        repeat (8) @(negedge clk);
        pins.raw_in[2] = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_glitch_level", 32'(pins.level_out[2]), 32'd1);
        check("t4_glitch_fall", 32'(fall_cnt[2] - f0), 32'd0);

        pins.raw_in[3] = 1'b1;
        repeat (8) @(negedge clk);
        reset_pulse(1);
        r0 = rise_cnt[3];
        wait_level(3, 1'b1, 20, lat);
        check("t5_latency_ok", 32'(lat >= 11 && lat <= 15), 32'd1);
        repeat (4) @(negedge clk);
        check("t5_single_rise", 32'(rise_cnt[3] - r0), 32'd1);

        reset_pulse(2);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            check("t6_tick", 32'(pins.tick_out), 32'((k % TD) == 0));
        end

        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 49) == 0) reset_pulse($urandom_range(1, 3));
            pins.raw_in = W'($urandom);
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
